// File: rtl/fft_stage_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fft_stage_sequencer_if                                     |
// | Description : Control/address bundle between FFT wrapper, stage          |
// |               sequencer and the butterfly datapath / RAM / twiddle ROM.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface fft_stage_sequencer_if #(
    parameter int LOG2N = 5
);
    localparam int SW = (LOG2N > 2) ? $clog2(LOG2N) : 1;
    localparam int AW = LOG2N;
    localparam int BW = LOG2N - 1;

    logic          EN;
    logic          START;
    logic          ABORT;
    logic          BUSY;
    logic          DONE;
    logic [LOG2N-1:0] STAGE_EN;
    logic [SW-1:0] S;
    logic          BF_VALID;
    logic [BW-1:0] BF_IDX;
    logic [AW-1:0] ADDR_A;
    logic [AW-1:0] ADDR_B;
    logic [BW-1:0] TW_ADDR;

    // The sequencer is the master: it consumes the control requests and
    // drives status plus the butterfly address stream.
    modport master (
        input  EN, START, ABORT,
        output BUSY, DONE, STAGE_EN, S, BF_VALID, BF_IDX, ADDR_A, ADDR_B, TW_ADDR
    );

    modport slave (
        output EN, START, ABORT,
        input  BUSY, DONE, STAGE_EN, S, BF_VALID, BF_IDX, ADDR_A, ADDR_B, TW_ADDR
    );
endinterface
`default_nettype wire

// File: rtl/fft_stage_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fft_stage_sequencer                                        |
// | Description : Radix-2 DIT FFT stage/butterfly sequencer with per-stage   |
// |               pipeline drain and start/done handshake.                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fft_stage_sequencer #(
    parameter int LOG2N    = 5,
    parameter int PIPE_LAT = 2
) (
    input  wire logic             CLK,
    input  wire logic             RST,
    fft_stage_sequencer_if.master bus
);
    localparam int SW = (LOG2N > 2) ? $clog2(LOG2N) : 1;
    localparam int AW = LOG2N;
    localparam int BW = LOG2N - 1;

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_RUN   = 2'd1;
    localparam logic [1:0] C_ST_DRAIN = 2'd2;
    localparam logic [1:0] C_ST_FIN   = 2'd3;

    localparam logic [BW-1:0] C_BF_LAST    = '1;
    localparam logic [SW-1:0] C_S_LAST     = SW'(LOG2N - 1);
    localparam logic [3:0]    C_DRAIN_LAST = 4'(PIPE_LAT - 1);
    localparam logic [SW:0]   C_TW_TOP     = (SW + 1)'(LOG2N - 1);

    logic [1:0]       state_q,    state_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic [LOG2N-1:0] stage_en_q, stage_en_d;
    logic [SW-1:0]    s_q,        s_d;
    logic             valid_q,    valid_d;
    logic [BW-1:0]    bf_idx_q,   bf_idx_d;
    logic [3:0]       drain_q,    drain_d;
    logic [AW-1:0]    addr_a_q,   addr_a_d;
    logic [AW-1:0]    addr_b_q,   addr_b_d;
    logic [BW-1:0]    tw_addr_q,  tw_addr_d;

    logic             w_stage_end;
    logic             w_clr;
    logic [AW-1:0]    w_bf_ext;
    logic [AW-1:0]    w_half;
    logic [AW-1:0]    w_grp_base;
    logic [AW-1:0]    w_pos;
    logic [AW-1:0]    w_addr_a;
    logic [BW-1:0]    w_pos_bw;
    logic [SW:0]      w_tw_sh;
    logic [BW-1:0]    w_tw;

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = done_q;
        stage_en_d  = stage_en_q;
        s_d         = s_q;
        valid_d     = valid_q;
        bf_idx_d    = bf_idx_q;
        drain_d     = drain_q;
        w_stage_end = 1'b0;

        if (bus.EN) begin
            if (bus.ABORT) begin
                state_d    = C_ST_IDLE;
                busy_d     = 1'b0;
                done_d     = 1'b0;
                stage_en_d = '0;
                s_d        = '0;
                valid_d    = 1'b0;
                bf_idx_d   = '0;
                drain_d    = '0;
            end else begin
                case (state_q)
                    C_ST_IDLE: begin
                        if (bus.START) begin
                            state_d    = C_ST_RUN;
                            busy_d     = 1'b1;
                            done_d     = 1'b0;
                            stage_en_d = LOG2N'(1);
                            s_d        = '0;
                            valid_d    = 1'b1;
                            bf_idx_d   = '0;
                        end
                    end
                    C_ST_RUN: begin
                        if (bf_idx_q != C_BF_LAST) begin
                            bf_idx_d = bf_idx_q + 1'b1;
                        end else if (PIPE_LAT > 0) begin
                            state_d = C_ST_DRAIN;
                            valid_d = 1'b0;
                            drain_d = '0;
                        end else begin
                            w_stage_end = 1'b1;
                        end
                    end
                    C_ST_DRAIN: begin
                        if (drain_q != C_DRAIN_LAST) begin
                            drain_d = drain_q + 4'd1;
                        end else begin
                            w_stage_end = 1'b1;
                        end
                    end
                    C_ST_FIN: begin
                        state_d = C_ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b0;
                    end
                    default: begin
                        state_d = C_ST_IDLE;
                    end
                endcase

                // Shared exit of a stage: either advance to the next one or finish.
                if (w_stage_end) begin
                    bf_idx_d = '0;
                    if (s_q == C_S_LAST) begin
                        state_d    = C_ST_FIN;
                        done_d     = 1'b1;
                        stage_en_d = '0;
                        s_d        = '0;
                        valid_d    = 1'b0;
                    end else begin
                        state_d    = C_ST_RUN;
                        s_d        = s_q + SW'(1);
                        stage_en_d = stage_en_q << 1;
                        valid_d    = 1'b1;
                    end
                end
            end
        end
    end

    // Addresses are computed from the next-cycle index so they register in step with BF_IDX.
    always_comb begin
        w_clr      = (state_d == C_ST_IDLE) || (state_d == C_ST_FIN);
        w_bf_ext   = {1'b0, bf_idx_d};
        w_half     = AW'(1) << s_d;
        w_grp_base = (w_bf_ext >> s_d) << s_d;
        w_pos      = w_bf_ext & (w_half - AW'(1));
        w_addr_a   = (w_grp_base << 1) | w_pos;
        w_pos_bw   = w_pos[BW-1:0];
        w_tw_sh    = C_TW_TOP - {1'b0, s_d};
        w_tw       = w_pos_bw << w_tw_sh;
        addr_a_d   = w_clr ? '0 : w_addr_a;
        addr_b_d   = w_clr ? '0 : (w_addr_a | w_half);
        tw_addr_d  = w_clr ? '0 : w_tw;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= C_ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            stage_en_q <= '0;
            s_q        <= '0;
            valid_q    <= 1'b0;
            bf_idx_q   <= '0;
            drain_q    <= '0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            tw_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            stage_en_q <= stage_en_d;
            s_q        <= s_d;
            valid_q    <= valid_d;
            bf_idx_q   <= bf_idx_d;
            drain_q    <= drain_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            tw_addr_q  <= tw_addr_d;
        end
    end

    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;
    assign bus.STAGE_EN = stage_en_q;
    assign bus.S        = s_q;
    assign bus.BF_VALID = valid_q;
    assign bus.BF_IDX   = bf_idx_q;
    assign bus.ADDR_A   = addr_a_q;
    assign bus.ADDR_B   = addr_b_q;
    assign bus.TW_ADDR  = tw_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fft_stage_sequencer                                     |
// | Description : Self-checking bench for a 32-point/drain-2 and an          |
// |               8-point/drain-0 sequencer against a cycle-index model.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_fft_stage_sequencer;
    logic clk  = 1'b0;
    logic rst5 = 1'b1;
    logic rst3 = 1'b1;
    always #5 clk = ~clk;

    fft_stage_sequencer_if #(.LOG2N(5)) if5 ();
    fft_stage_sequencer_if #(.LOG2N(3)) if3 ();

    fft_stage_sequencer #(.LOG2N(5), .PIPE_LAT(2)) dut5 (.CLK(clk), .RST(rst5), .bus(if5));
    fft_stage_sequencer #(.LOG2N(3), .PIPE_LAT(0)) dut3 (.CLK(clk), .RST(rst3), .bus(if3));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Model: a transform is just a running cycle index t; stage and offset follow by division.
    bit m5_act = 1'b0, m5_clean = 1'b1;
    int m5_t   = 0;
    bit m3_act = 1'b0, m3_clean = 1'b1;
    int m3_t   = 0;

    always @(posedge clk or posedge rst5) begin
        if (rst5) begin
            m5_act <= 1'b0; m5_clean <= 1'b1; m5_t <= 0;
        end else if (if5.EN === 1'b1) begin
            if (if5.ABORT === 1'b1) begin
                m5_act <= 1'b0; m5_clean <= 1'b1;
            end else if (!m5_act) begin
                if (if5.START === 1'b1) begin m5_act <= 1'b1; m5_clean <= 1'b0; m5_t <= 0; end
            end else if (m5_t == 5 * (16 + 2)) begin
                m5_act <= 1'b0;
            end else begin
                m5_t <= m5_t + 1;
            end
        end
    end

    always @(posedge clk or posedge rst3) begin
        if (rst3) begin
            m3_act <= 1'b0; m3_clean <= 1'b1; m3_t <= 0;
        end else if (if3.EN === 1'b1) begin
            if (if3.ABORT === 1'b1) begin
                m3_act <= 1'b0; m3_clean <= 1'b1;
            end else if (!m3_act) begin
                if (if3.START === 1'b1) begin m3_act <= 1'b1; m3_clean <= 1'b0; m3_t <= 0; end
            end else if (m3_t == 3 * (4 + 0)) begin
                m3_act <= 1'b0;
            end else begin
                m3_t <= m3_t + 1;
            end
        end
    end

    task automatic check_model(input string tag, input int L, input int P,
                               input bit act, input int t, input bit clean,
                               input logic busy, input logic done, input logic [31:0] sen,
                               input logic [31:0] s, input logic valid, input logic [31:0] bf,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] tw);
        int h, per, stg, off, half, pos, ea;
        h   = 1 << (L - 1);
        per = h + P;
        if (!act) begin
            chk({tag, ".idle.busy"}, busy, 0);
            chk({tag, ".idle.done"}, done, 0);
            chk({tag, ".idle.stage_en"}, sen, 0);
            chk({tag, ".idle.valid"}, valid, 0);
            if (clean) begin
                chk({tag, ".idle.s"}, s, 0);
                chk({tag, ".idle.bf"}, bf, 0);
                chk({tag, ".idle.addr_a"}, a, 0);
                chk({tag, ".idle.addr_b"}, b, 0);
                chk({tag, ".idle.tw"}, tw, 0);
            end
        end else if (t == L * per) begin
            chk({tag, ".fin.busy"}, busy, 1);
            chk({tag, ".fin.done"}, done, 1);
            chk({tag, ".fin.stage_en"}, sen, 0);
            chk({tag, ".fin.valid"}, valid, 0);
        end else begin
            stg  = t / per;
            off  = t % per;
            half = 1 << stg;
            chk({tag, ".busy"}, busy, 1);
            chk({tag, ".done"}, done, 0);
            chk({tag, ".stage_en"}, sen, 1 << stg);
            chk({tag, ".s"}, s, stg);
            chk({tag, ".valid"}, valid, (off < h) ? 1 : 0);
            if (off < h) begin
                pos = off % half;
                ea  = (off / half) * 2 * half + pos;
                chk({tag, ".bf_idx"}, bf, off);
                chk({tag, ".addr_a"}, a, ea);
                chk({tag, ".addr_b"}, b, ea + half);
                chk({tag, ".tw_addr"}, tw, pos << (L - 1 - stg));
            end
        end
    endtask

    int   done5_cnt = 0, busy5_cnt = 0, valid5_cnt = 0, busy5_rise = 0, done5_lat = 0, addr_hits = 0;
    int   done3_cnt = 0, valid3_cnt = 0, busy3_rise = 0, done3_lat = 0;
    logic busy5_prev = 1'b0, busy3_prev = 1'b0;

    always @(negedge clk) begin
        check_model("d5", 5, 2, m5_act, m5_t, m5_clean, if5.BUSY, if5.DONE, 32'(if5.STAGE_EN),
                    32'(if5.S), if5.BF_VALID, 32'(if5.BF_IDX), 32'(if5.ADDR_A), 32'(if5.ADDR_B),
                    32'(if5.TW_ADDR));
        check_model("d3", 3, 0, m3_act, m3_t, m3_clean, if3.BUSY, if3.DONE, 32'(if3.STAGE_EN),
                    32'(if3.S), if3.BF_VALID, 32'(if3.BF_IDX), 32'(if3.ADDR_A), 32'(if3.ADDR_B),
                    32'(if3.TW_ADDR));

        if (if5.BUSY === 1'b1 && busy5_prev !== 1'b1) busy5_rise = cyc;
        if (if5.BUSY === 1'b1) busy5_cnt++;
        if (if5.BF_VALID === 1'b1) valid5_cnt++;
        if (if5.DONE === 1'b1) begin done5_cnt++; done5_lat = cyc - busy5_rise; end
        busy5_prev = if5.BUSY;

        if (if3.BUSY === 1'b1 && busy3_prev !== 1'b1) busy3_rise = cyc;
        if (if3.BF_VALID === 1'b1) valid3_cnt++;
        if (if3.DONE === 1'b1) begin done3_cnt++; done3_lat = cyc - busy3_rise; end
        busy3_prev = if3.BUSY;

        if (if5.BF_VALID === 1'b1 && if5.S == 3'd2 && if5.BF_IDX == 4'd5) begin
            addr_hits++;
            chk("lit.s2b5.addr_a", 32'(if5.ADDR_A), 9);
            chk("lit.s2b5.addr_b", 32'(if5.ADDR_B), 13);
            chk("lit.s2b5.tw", 32'(if5.TW_ADDR), 4);
        end
        if (if5.BF_VALID === 1'b1 && if5.S == 3'd0 && if5.BF_IDX == 4'd15) begin
            addr_hits++;
            chk("lit.s0b15.addr_a", 32'(if5.ADDR_A), 30);
            chk("lit.s0b15.addr_b", 32'(if5.ADDR_B), 31);
            chk("lit.s0b15.tw", 32'(if5.TW_ADDR), 0);
        end
        if (if5.BF_VALID === 1'b1 && if5.S == 3'd4 && if5.BF_IDX == 4'd15) begin
            addr_hits++;
            chk("lit.s4b15.addr_a", 32'(if5.ADDR_A), 15);
            chk("lit.s4b15.addr_b", 32'(if5.ADDR_B), 31);
            chk("lit.s4b15.tw", 32'(if5.TW_ADDR), 15);
        end
    end

    task automatic pulse_start5();
        if5.START = 1'b1;
        @(posedge clk); #2;
        if5.START = 1'b0;
    endtask

    task automatic wait_done5(input int budget);
        for (int i = 0; i < budget && done5_cnt == 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        if5.EN = 1'b0; if5.START = 1'b0; if5.ABORT = 1'b0;
        if3.EN = 1'b0; if3.START = 1'b0; if3.ABORT = 1'b0;
        #47;
        rst5 = 1'b0;
        rst3 = 1'b0;
        chk("rst.busy", if5.BUSY, 0);
        chk("rst.done", if5.DONE, 0);
        chk("rst.stage_en", 32'(if5.STAGE_EN), 0);
        chk("rst.valid", if5.BF_VALID, 0);
        chk("rst.addr_b", 32'(if5.ADDR_B), 0);
        chk("rst.busy3", if3.BUSY, 0);

        // START with EN low must not be taken.
        @(posedge clk); #2;
        if5.START = 1'b1; if3.START = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        chk("en0.busy5", if5.BUSY, 0);
        chk("en0.stage_en5", 32'(if5.STAGE_EN), 0);
        chk("en0.busy3", if3.BUSY, 0);
        if5.START = 1'b0; if3.START = 1'b0;

        // Full 32-point transform.
        done5_cnt = 0; busy5_cnt = 0; valid5_cnt = 0; addr_hits = 0;
        if5.EN = 1'b1;
        pulse_start5();
        wait_done5(200);
        chk("run1.done_once", done5_cnt, 1);
        chk("run1.done_lat", done5_lat, 90);
        chk("run1.busy_cycles", busy5_cnt, 91);
        chk("run1.valid_cycles", valid5_cnt, 80);
        chk("run1.addr_hits", addr_hits, 3);

        // EN stall mid-stage 1.
        done5_cnt = 0;
        pulse_start5();
        for (int i = 0; i < 100 && !(if5.BF_VALID === 1'b1 && if5.S == 3'd1 && if5.BF_IDX == 4'd6); i++)
            @(negedge clk);
        chk("stall.reach_bf", 32'(if5.BF_IDX), 6);
        if5.EN = 1'b0;
        repeat (7) begin
            @(posedge clk); #2;
            chk("stall.hold_bf", 32'(if5.BF_IDX), 6);
            chk("stall.hold_s", 32'(if5.S), 1);
        end
        if5.EN = 1'b1;
        @(posedge clk); #2;
        chk("stall.resume_bf", 32'(if5.BF_IDX), 7);
        wait_done5(200);
        chk("stall.done_once", done5_cnt, 1);
        chk("stall.done_lat", done5_lat, 97);

        // START while busy is ignored; ABORT in stage 3.
        done5_cnt = 0;
        pulse_start5();
        repeat (5) @(posedge clk);
        #2;
        pulse_start5();
        for (int i = 0; i < 100 && !(if5.BF_VALID === 1'b1 && if5.S == 3'd3); i++) @(negedge clk);
        chk("abort.reach_s", 32'(if5.S), 3);
        if5.ABORT = 1'b1;
        @(posedge clk); #2;
        if5.ABORT = 1'b0;
        chk("abort.busy", if5.BUSY, 0);
        chk("abort.stage_en", 32'(if5.STAGE_EN), 0);
        chk("abort.valid", if5.BF_VALID, 0);
        repeat (3) @(posedge clk);
        #2;
        chk("abort.no_done", done5_cnt, 0);
        pulse_start5();
        wait_done5(200);
        chk("abort.rerun_done_once", done5_cnt, 1);
        chk("abort.rerun_lat", done5_lat, 90);

        // 8-point, no drain.
        done3_cnt = 0; valid3_cnt = 0;
        if3.EN = 1'b1;
        if3.START = 1'b1;
        @(posedge clk); #2;
        if3.START = 1'b0;
        for (int i = 0; i < 50 && done3_cnt == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("d3.done_once", done3_cnt, 1);
        chk("d3.done_lat", done3_lat, 12);
        chk("d3.valid_cycles", valid3_cnt, 12);

        // Asynchronous reset mid-stage 1.
        done3_cnt = 0;
        if3.START = 1'b1;
        @(posedge clk); #2;
        if3.START = 1'b0;
        for (int i = 0; i < 30 && !(if3.BF_VALID === 1'b1 && if3.S == 2'd1 && if3.BF_IDX == 2'd1); i++)
            @(negedge clk);
        chk("d3rst.reach_s", 32'(if3.S), 1);
        #1;
        rst3 = 1'b1;
        #1;
        chk("d3rst.busy", if3.BUSY, 0);
        chk("d3rst.stage_en", 32'(if3.STAGE_EN), 0);
        chk("d3rst.valid", if3.BF_VALID, 0);
        chk("d3rst.bf", 32'(if3.BF_IDX), 0);
        chk("d3rst.s", 32'(if3.S), 0);
        @(posedge clk); #2;
        rst3 = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        chk("d3rst.no_done", done3_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire
